// File: rtl/dds_sweep_pkg.sv
// Shared types and default widths/addresses for the DDS sweep sequencer.
package dds_sweep_pkg;

  localparam int unsigned DEF_ACC_W = 28;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_A_W   = 5;

  localparam logic [4:0] DEF_PINC_ADDR = 5'd0;
  localparam logic [4:0] DEF_POFF_ADDR = 5'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_POFF,
    S_WR_PINC,
    S_DWELL
  } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that measures the dwell time spent at each frequency.
module dds_dwell_timer
  import dds_sweep_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_en,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Drives the DDS register-write bus to produce linear (optionally looping)
// frequency sweeps: one phase-offset write, then stepped phase-increment writes.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int unsigned    ACC_W     = DEF_ACC_W,
  parameter int unsigned    A_W       = DEF_A_W,
  parameter int unsigned    CNT_W     = DEF_CNT_W,
  parameter logic [A_W-1:0] PINC_ADDR = A_W'(DEF_PINC_ADDR),
  parameter logic [A_W-1:0] POFF_ADDR = A_W'(DEF_POFF_ADDR)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             LOOP,
  input  logic [ACC_W-1:0] PHASE_INIT,
  input  logic [ACC_W-1:0] F_START,
  input  logic [ACC_W-1:0] F_STEP,
  input  logic [CNT_W-1:0] STEP_COUNT,
  input  logic [CNT_W-1:0] DWELL,
  output logic [ACC_W-1:0] DATA,
  output logic             WE,
  output logic [A_W-1:0]   A,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] STEP_IDX
);

  sweep_state_t     r_state;
  logic [ACC_W-1:0] r_f_start;
  logic [ACC_W-1:0] r_f_step;
  logic [ACC_W-1:0] r_freq;
  logic [CNT_W-1:0] r_last_idx;
  logic [CNT_W-1:0] r_dwell_m1;
  logic             r_loop;
  logic [ACC_W-1:0] r_data;
  logic             r_we;
  logic [A_W-1:0]   r_a;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_step_idx;

  logic             w_zero;
  logic             w_timer_load;
  logic             w_timer_en;
  logic [ACC_W-1:0] w_freq_next;
  logic [CNT_W-1:0] w_n_m1;
  logic [CNT_W-1:0] w_d_m1;

  // Zero-valued count/dwell fields are treated as one.
  assign w_n_m1       = (STEP_COUNT == '0) ? '0 : STEP_COUNT - CNT_W'(1);
  assign w_d_m1       = (DWELL == '0) ? '0 : DWELL - CNT_W'(1);
  assign w_freq_next  = r_freq + r_f_step;
  assign w_timer_load = (r_state == S_WR_PINC);
  assign w_timer_en   = (r_state == S_DWELL);

  dds_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_load   (w_timer_load),
    .i_value  (r_dwell_m1),
    .i_en     (w_timer_en),
    .o_zero_c (w_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_f_start  <= '0;
      r_f_step   <= '0;
      r_freq     <= '0;
      r_last_idx <= '0;
      r_dwell_m1 <= '0;
      r_loop     <= 1'b0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_a        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_step_idx <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      // Abort: return to idle without touching the held DATA/A values.
      if (STOP && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (START && !STOP) begin
              r_f_start  <= F_START;
              r_f_step   <= F_STEP;
              r_last_idx <= w_n_m1;
              r_dwell_m1 <= w_d_m1;
              r_loop     <= LOOP;
              r_data     <= PHASE_INIT;
              r_a        <= POFF_ADDR;
              r_we       <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_WR_POFF;
            end
          end
          S_WR_POFF: begin
            r_freq     <= r_f_start;
            r_data     <= r_f_start;
            r_a        <= PINC_ADDR;
            r_we       <= 1'b1;
            r_step_idx <= '0;
            r_state    <= S_WR_PINC;
          end
          S_WR_PINC: begin
            r_state <= S_DWELL;
          end
          S_DWELL: begin
            if (w_zero) begin
              if (r_step_idx < r_last_idx) begin
                r_freq     <= w_freq_next;
                r_data     <= w_freq_next;
                r_a        <= PINC_ADDR;
                r_we       <= 1'b1;
                r_step_idx <= r_step_idx + CNT_W'(1);
                r_state    <= S_WR_PINC;
              end else if (r_loop) begin
                r_freq     <= r_f_start;
                r_data     <= r_f_start;
                r_a        <= PINC_ADDR;
                r_we       <= 1'b1;
                r_step_idx <= '0;
                r_state    <= S_WR_PINC;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign DATA     = r_data;
  assign WE       = r_we;
  assign A        = r_a;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign STEP_IDX = r_step_idx;

endmodule
